idex_latch: RTL and testbench

IDEX_LATCH -- requirements
Module: idex_latch

---
 rtl/idex_latch_pkg.sv | 32 +++
 rtl/idex_dbg_counter.sv | 24 ++
 rtl/idex_latch.sv | 148 ++++++++++++++
 tb/tb_idex_latch.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idex_latch_pkg.sv
// Shared pipeline definitions for the ID/EX latch.
// Holds the ID/EX FSM state encoding, the default control-bundle width,
// the control-bundle field positions and the debug counter width.
package idex_latch_pkg;

    // Default width of the packed ID control bundle.
    localparam int unsigned PKG_BITS_CTRL = 16;

    // Width of the debug load counter.
    localparam int unsigned DBG_CNT_W = 32;

    // ID/EX FSM state encoding.
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    // Bit positions of the fields inside the control bundle.
    localparam int unsigned CTRL_REG_DST    = 0;
    localparam int unsigned CTRL_ALU_SRC    = 1;
    localparam int unsigned CTRL_MEM_TO_REG = 2;
    localparam int unsigned CTRL_REG_WRITE  = 3;
    localparam int unsigned CTRL_MEM_READ   = 4;
    localparam int unsigned CTRL_MEM_WRITE  = 5;
    localparam int unsigned CTRL_BRANCH     = 6;
    localparam int unsigned CTRL_JUMP       = 7;
    localparam int unsigned CTRL_ALU_OP_LSB = 8;
    localparam int unsigned CTRL_ALU_OP_MSB = 11;
    localparam int unsigned CTRL_WIDTH_LSB  = 12;
    localparam int unsigned CTRL_WIDTH_MSB  = 13;
    localparam int unsigned CTRL_UNSIGNED   = 14;
    localparam int unsigned CTRL_LINK       = 15;

endpackage

// File: rtl/idex_dbg_counter.sv
// Wrapping debug counter of valid ID/EX loads.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_inc          : add one on this edge
//   o_count        : registered count, wraps from all-ones to zero
module idex_dbg_counter
    import idex_latch_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_inc,
    output logic [DBG_CNT_W-1:0] o_count
);

    // Natural modulo-2^N wrap of the adder provides the roll-over.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_count <= '0;
        end else if (i_inc) begin
            o_count <= o_count + DBG_CNT_W'(1);
        end
    end

endmodule

// File: rtl/idex_latch.sv
// ID/EX pipeline latch with debug stepping, flush, hold and HALT capture.
// Optional feature: define IDEX_DEBUG_CNT_EN to include the valid-load counter
// on o_dbg_count; otherwise o_dbg_count is tied to zero.
// Ports:
//   i_clk, i_reset          : clock, asynchronous active-high reset
//   i_step                  : 0 freezes all state
//   i_flush / i_hold        : insert bubble / keep current entry
//   i_valid, i_halt         : ID instruction is real / is HALT
//   i_ctrl, i_rs, i_rt, i_extension_result, i_pc4, i_addr_* : ID payload
//   o_*                     : registered EX copies, o_valid, sticky o_halt
//   o_dbg_count             : valid-load count (zero when feature disabled)
module idex_latch
    import idex_latch_pkg::*;
#(
    parameter int unsigned BITS_SIZE = 32,
    parameter int unsigned BITS_REGS = 5,
    parameter int unsigned BITS_CTRL = PKG_BITS_CTRL
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_step,
    input  logic                 i_flush,
    input  logic                 i_hold,
    input  logic                 i_valid,
    input  logic                 i_halt,
    input  logic [BITS_CTRL-1:0] i_ctrl,
    input  logic [BITS_SIZE-1:0] i_rs,
    input  logic [BITS_SIZE-1:0] i_rt,
    input  logic [BITS_SIZE-1:0] i_extension_result,
    input  logic [BITS_SIZE-1:0] i_pc4,
    input  logic [BITS_REGS-1:0] i_addr_rs,
    input  logic [BITS_REGS-1:0] i_addr_rt,
    input  logic [BITS_REGS-1:0] i_addr_rd,
    output logic [BITS_CTRL-1:0] o_ctrl,
    output logic [BITS_SIZE-1:0] o_rs,
    output logic [BITS_SIZE-1:0] o_rt,
    output logic [BITS_SIZE-1:0] o_extension_result,
    output logic [BITS_SIZE-1:0] o_pc4,
    output logic [BITS_REGS-1:0] o_addr_rs,
    output logic [BITS_REGS-1:0] o_addr_rt,
    output logic [BITS_REGS-1:0] o_addr_rd,
    output logic                 o_valid,
    output logic                 o_halt,
    output logic [DBG_CNT_W-1:0] o_dbg_count
);

    logic [0:0]           state;
    logic [0:0]           state_n;
    logic [BITS_CTRL-1:0] ctrl_n;
    logic [BITS_SIZE-1:0] rs_n;
    logic [BITS_SIZE-1:0] rt_n;
    logic [BITS_SIZE-1:0] ext_n;
    logic [BITS_SIZE-1:0] pc4_n;
    logic [BITS_REGS-1:0] addr_rs_n;
    logic [BITS_REGS-1:0] addr_rt_n;
    logic [BITS_REGS-1:0] addr_rd_n;
    logic                 valid_n;
    logic                 halt_n;

    // Next-state and next-entry selection: flush, then HALTED, then hold, then load.
    always_comb begin
        state_n   = state;
        ctrl_n    = o_ctrl;
        rs_n      = o_rs;
        rt_n      = o_rt;
        ext_n     = o_extension_result;
        pc4_n     = o_pc4;
        addr_rs_n = o_addr_rs;
        addr_rt_n = o_addr_rt;
        addr_rd_n = o_addr_rd;
        valid_n   = o_valid;
        halt_n    = o_halt;

        if (i_step) begin
            if (i_flush || (state == ST_HALTED)) begin
                // Bubble: o_halt is deliberately left as is.
                ctrl_n    = '0;
                rs_n      = '0;
                rt_n      = '0;
                ext_n     = '0;
                pc4_n     = '0;
                addr_rs_n = '0;
                addr_rt_n = '0;
                addr_rd_n = '0;
                valid_n   = 1'b0;
            end else if (!i_hold) begin
                ctrl_n    = i_ctrl;
                rs_n      = i_rs;
                rt_n      = i_rt;
                ext_n     = i_extension_result;
                pc4_n     = i_pc4;
                addr_rs_n = i_addr_rs;
                addr_rt_n = i_addr_rt;
                addr_rd_n = i_addr_rd;
                valid_n   = i_valid;
                if (i_valid && i_halt) begin
                    state_n = ST_HALTED;
                    halt_n  = 1'b1;
                end
            end
        end
    end

    // State and output registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state              <= ST_RUN;
            o_ctrl             <= '0;
            o_rs               <= '0;
            o_rt               <= '0;
            o_extension_result <= '0;
            o_pc4              <= '0;
            o_addr_rs          <= '0;
            o_addr_rt          <= '0;
            o_addr_rd          <= '0;
            o_valid            <= 1'b0;
            o_halt             <= 1'b0;
        end else begin
            state              <= state_n;
            o_ctrl             <= ctrl_n;
            o_rs               <= rs_n;
            o_rt               <= rt_n;
            o_extension_result <= ext_n;
            o_pc4              <= pc4_n;
            o_addr_rs          <= addr_rs_n;
            o_addr_rt          <= addr_rt_n;
            o_addr_rd          <= addr_rd_n;
            o_valid            <= valid_n;
            o_halt             <= halt_n;
        end
    end

`ifdef IDEX_DEBUG_CNT_EN
    // Count only real loads that place a valid instruction into EX.
    logic load_valid_c;
    assign load_valid_c = i_step && !i_flush && (state == ST_RUN) && !i_hold && i_valid;

    idex_dbg_counter u_dbg_counter (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (load_valid_c),
        .o_count (o_dbg_count)
    );
`else
    assign o_dbg_count = '0;
`endif

endmodule

// File: tb/tb_idex_latch.sv
// Scoreboard bench for idex_latch: the driver applies stimulus at the falling
// edge and pushes the reference model's prediction; the monitor pops and
// compares one entry after every rising edge.
module tb_idex_latch;

    typedef struct packed {
        logic [15:0] ctrl;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ext;
        logic [31:0] pc4;
        logic [4:0]  ars;
        logic [4:0]  art;
        logic [4:0]  ard;
        logic        valid;
        logic        halt;
        logic [31:0] cnt;
    } out_t;

    typedef struct {
        bit          step;
        bit          flush;
        bit          hold;
        bit          valid;
        bit          halt;
        logic [15:0] ctrl;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] ext;
        logic [31:0] pc4;
        logic [4:0]  ars;
        logic [4:0]  art;
        logic [4:0]  ard;
    } stim_t;

    logic        clk;
    logic        i_reset;
    logic        i_step, i_flush, i_hold, i_valid, i_halt;
    logic [15:0] i_ctrl;
    logic [31:0] i_rs, i_rt, i_extension_result, i_pc4;
    logic [4:0]  i_addr_rs, i_addr_rt, i_addr_rd;
    logic [15:0] o_ctrl;
    logic [31:0] o_rs, o_rt, o_extension_result, o_pc4;
    logic [4:0]  o_addr_rs, o_addr_rt, o_addr_rd;
    logic        o_valid, o_halt;
    logic [31:0] o_dbg_count;

    idex_latch dut (
        .i_clk              (clk),
        .i_reset            (i_reset),
        .i_step             (i_step),
        .i_flush            (i_flush),
        .i_hold             (i_hold),
        .i_valid            (i_valid),
        .i_halt             (i_halt),
        .i_ctrl             (i_ctrl),
        .i_rs               (i_rs),
        .i_rt               (i_rt),
        .i_extension_result (i_extension_result),
        .i_pc4              (i_pc4),
        .i_addr_rs          (i_addr_rs),
        .i_addr_rt          (i_addr_rt),
        .i_addr_rd          (i_addr_rd),
        .o_ctrl             (o_ctrl),
        .o_rs               (o_rs),
        .o_rt               (o_rt),
        .o_extension_result (o_extension_result),
        .o_pc4              (o_pc4),
        .o_addr_rs          (o_addr_rs),
        .o_addr_rt          (o_addr_rt),
        .o_addr_rd          (o_addr_rd),
        .o_valid            (o_valid),
        .o_halt             (o_halt),
        .o_dbg_count        (o_dbg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    out_t sb[$];

    // Reference model: expected EX entry and whether HALT has been captured.
    out_t m_out;
    bit   m_halted;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic out_t dut_out();
        return {o_ctrl, o_rs, o_rt, o_extension_result, o_pc4,
                o_addr_rs, o_addr_rt, o_addr_rd, o_valid, o_halt, o_dbg_count};
    endfunction

    // One rising edge of the latch, stated as the pipeline rules.
    task automatic model_edge(input stim_t s);
        if (!s.step) return;
        if (s.flush || m_halted) begin
            m_out.ctrl  = '0;  m_out.rs  = '0;  m_out.rt  = '0;
            m_out.ext   = '0;  m_out.pc4 = '0;
            m_out.ars   = '0;  m_out.art = '0;  m_out.ard = '0;
            m_out.valid = 1'b0;
        end else if (!s.hold) begin
            m_out.ctrl  = s.ctrl;  m_out.rs  = s.rs;  m_out.rt  = s.rt;
            m_out.ext   = s.ext;   m_out.pc4 = s.pc4;
            m_out.ars   = s.ars;   m_out.art = s.art; m_out.ard = s.ard;
            m_out.valid = s.valid;
`ifdef IDEX_DEBUG_CNT_EN
            if (s.valid) m_out.cnt = m_out.cnt + 32'd1;
`endif
            if (s.valid && s.halt) begin
                m_halted   = 1'b1;
                m_out.halt = 1'b1;
            end
        end
    endtask

    function automatic stim_t rand_stim();
        stim_t s;
        s.step  = ($urandom_range(0, 99) < 80);
        s.flush = ($urandom_range(0, 99) < 10);
        s.hold  = ($urandom_range(0, 99) < 20);
        s.valid = ($urandom_range(0, 99) < 70);
        s.halt  = ($urandom_range(0, 99) < 4);
        s.ctrl  = 16'($urandom);
        s.rs    = $urandom;
        s.rt    = $urandom;
        s.ext   = $urandom;
        s.pc4   = $urandom;
        s.ars   = 5'($urandom);
        s.art   = 5'($urandom);
        s.ard   = 5'($urandom);
        return s;
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive(input stim_t s);
        i_step = s.step;  i_flush = s.flush; i_hold = s.hold;
        i_valid = s.valid; i_halt = s.halt; i_ctrl = s.ctrl;
        i_rs = s.rs; i_rt = s.rt; i_extension_result = s.ext; i_pc4 = s.pc4;
        i_addr_rs = s.ars; i_addr_rt = s.art; i_addr_rd = s.ard;
        model_edge(s);
        sb.push_back(m_out);
        @(negedge clk);
    endtask

    // Asynchronous reset between edges, checked before any clock edge.
    task automatic do_reset();
        #2;
        i_reset = 1'b1;
        i_step  = 1'b0;
        #1;
        chk("async_reset", dut_out(), '0);
        m_out    = '0;
        m_halted = 1'b0;
        sb.push_back(m_out);
        @(negedge clk);
        i_reset = 1'b0;
    endtask

    // Monitor: one prediction per rising edge once stimulus has started.
    initial begin
        out_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("scoreboard", dut_out(), e);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t       s;
        logic [31:0] cnt_before;
        i_reset = 1'b1;
        i_step = 0; i_flush = 0; i_hold = 0; i_valid = 0; i_halt = 0;
        i_ctrl = '0; i_rs = '0; i_rt = '0; i_extension_result = '0; i_pc4 = '0;
        i_addr_rs = '0; i_addr_rt = '0; i_addr_rd = '0;
        m_out = '0;
        m_halted = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_reset();

        // Stepped load right after reset release.
        s = rand_stim();
        s.step = 1; s.flush = 0; s.hold = 0; s.valid = 1; s.halt = 0;
        s.rs = 32'h11; s.rt = 32'h22; s.pc4 = 32'h104; s.ard = 5'd5;
        drive(s);
        chk("load_rs", o_rs, 32'h11);
        chk("load_rt", o_rt, 32'h22);
        chk("load_pc4", o_pc4, 32'h104);
        chk("load_rd", o_addr_rd, 5'd5);
        chk("load_valid", o_valid, 1'b1);
`ifdef IDEX_DEBUG_CNT_EN
        chk("load_count", o_dbg_count, 32'd1);
`else
        chk("load_count", o_dbg_count, 32'd0);
`endif

        // Freeze with changing inputs.
        for (int i = 0; i < 3; i++) begin
            s = rand_stim();
            s.step = 0; s.valid = 1;
            drive(s);
        end
        chk("freeze_rs", o_rs, 32'h11);
        chk("freeze_valid", o_valid, 1'b1);

        // Flush beats hold; then hold keeps the bubble.
        cnt_before = m_out.cnt;
        s = rand_stim();
        s.step = 1; s.flush = 1; s.hold = 1; s.valid = 1; s.halt = 0;
        drive(s);
        chk("flush_valid", o_valid, 1'b0);
        chk("flush_ctrl", o_ctrl, 16'h0);
        chk("flush_count", o_dbg_count, cnt_before);
        s = rand_stim();
        s.step = 1; s.flush = 0; s.hold = 1; s.valid = 1;
        drive(s);
        chk("hold_valid", o_valid, 1'b0);
        chk("hold_rs", o_rs, 32'h0);

        // Invalid load still copies data.
        s = rand_stim();
        s.step = 1; s.flush = 0; s.hold = 0; s.valid = 0; s.rt = 32'hCAFE_0001;
        drive(s);
        chk("invalid_load_rt", o_rt, 32'hCAFE_0001);
        chk("invalid_load_valid", o_valid, 1'b0);

        // Flush together with HALT: no transition.
        s = rand_stim();
        s.step = 1; s.flush = 1; s.valid = 1; s.halt = 1;
        drive(s);
        chk("flush_halt", o_halt, 1'b0);

        // HALT capture, bubbles afterwards, cleared by reset.
        s = rand_stim();
        s.step = 1; s.flush = 0; s.hold = 0; s.valid = 1; s.halt = 1;
        drive(s);
        chk("halt_set", o_halt, 1'b1);
        chk("halt_valid", o_valid, 1'b1);
        for (int i = 0; i < 2; i++) begin
            s = rand_stim();
            s.step = 1; s.flush = 0; s.hold = (i == 1); s.valid = 1; s.halt = 0;
            drive(s);
            chk("halted_valid", o_valid, 1'b0);
            chk("halted_halt", o_halt, 1'b1);
        end
        do_reset();
        chk("halt_cleared", o_halt, 1'b0);

        // Counter wrap, then reset during a hold.
`ifdef IDEX_DEBUG_CNT_EN
        dut.u_dbg_counter.o_count = 32'hFFFF_FFFF;
        m_out.cnt = 32'hFFFF_FFFF;
`endif
        s = rand_stim();
        s.step = 1; s.flush = 0; s.hold = 0; s.valid = 1; s.halt = 0;
        drive(s);
        chk("wrap_count", o_dbg_count, 32'd0);
        s = rand_stim();
        s.step = 1; s.flush = 0; s.hold = 1;
        drive(s);
        do_reset();

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 3) do_reset();
            else drive(rand_stim());
        end

        chk("sb_drain", 256'(sb.size()), 256'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
